// File: rtl/traffic_source_arbiter.sv
`timescale 1ns/1ps
// traffic_source_arbiter
// Fixed-priority one-hot source select for the traffic-light state mux.
// A newly granted source is held for MIN_DWELL cycles; a normal switch
// passes through CLEAR_CYCLES cycles of the reset-pattern source. A reset
// pattern request preempts everything, including an in-progress clearance.
module traffic_source_arbiter #(
    parameter int unsigned MIN_DWELL    = 8,
    parameter int unsigned CLEAR_CYCLES = 3,
    parameter int unsigned CW           = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] req,
    output logic [5:0] enb,
    output logic       busy,
    output logic       grant_chg
);

    localparam logic [5:0]    SRC_RESET  = 6'b000010;
    localparam logic [CW-1:0] DWELL_LAST = CW'(MIN_DWELL - 1);
    localparam logic [CW-1:0] CLEAR_LAST = CW'(CLEAR_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    typedef enum logic [1:0] {
        ST_DWELL = 2'd0,
        ST_READY = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [5:0]    tgt_q, tgt_d;
    logic [5:0]    enb_q, enb_d;
    logic          busy_q, busy_d;
    logic          grant_chg_q, grant_chg_d;

    logic [5:0]    winner;
    logic          has_winner;
    logic          preempt;
    logic          switch_req;
    logic          clear_done;

    // Priority encode: reset pattern > online > mode1 > mode2 > mode3 > mode4.
    always_comb begin
        winner = '0;
        if (req[1]) begin
            winner = 6'b000010;
        end else if (req[0]) begin
            winner = 6'b000001;
        end else if (req[5]) begin
            winner = 6'b100000;
        end else if (req[4]) begin
            winner = 6'b010000;
        end else if (req[3]) begin
            winner = 6'b001000;
        end else if (req[2]) begin
            winner = 6'b000100;
        end
    end

    assign has_winner = |req;

    // A reset-pattern request only acts if it would change something:
    // either a non-reset source is shown or a clearance is in progress.
    assign preempt    = req[1] && ((enb_q != SRC_RESET) || (state_q == ST_CLEAR));
    assign switch_req = (state_q == ST_READY) && has_winner && (winner != enb_q);
    assign clear_done = (state_q == ST_CLEAR) && (cnt_q == CLEAR_LAST);

    // State register: all flops, asynchronous active-high reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_DWELL;
            cnt_q       <= '0;
            tgt_q       <= SRC_RESET;
            enb_q       <= SRC_RESET;
            busy_q      <= 1'b0;
            grant_chg_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tgt_q       <= tgt_d;
            enb_q       <= enb_d;
            busy_q      <= busy_d;
            grant_chg_q <= grant_chg_d;
        end
    end

    // Next-state logic: preemption first, then dwell / ready / clear sequencing.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tgt_d   = tgt_q;
        if (preempt) begin
            state_d = ST_DWELL;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_DWELL: begin
                    if (cnt_q == DWELL_LAST) begin
                        state_d = ST_READY;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_READY: begin
                    if (switch_req) begin
                        tgt_d   = winner;
                        cnt_d   = '0;
                        state_d = ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    if (clear_done) begin
                        cnt_d   = '0;
                        state_d = ST_DWELL;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = ST_DWELL;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Output logic: registered select, busy flag and one-cycle change pulse.
    // The pulse also fires on CLEAR entry from the reset pattern and on a
    // preemption abort from CLEAR, where the select value itself is unchanged.
    always_comb begin
        enb_d       = enb_q;
        busy_d      = busy_q;
        grant_chg_d = 1'b0;
        if (preempt) begin
            enb_d       = SRC_RESET;
            busy_d      = 1'b0;
            grant_chg_d = 1'b1;
        end else if (switch_req) begin
            enb_d       = SRC_RESET;
            busy_d      = 1'b1;
            grant_chg_d = 1'b1;
        end else if (clear_done) begin
            enb_d       = tgt_q;
            busy_d      = 1'b0;
            grant_chg_d = 1'b1;
        end
    end

    assign enb       = enb_q;
    assign busy      = busy_q;
    assign grant_chg = grant_chg_q;

endmodule

// File: tb/tb_traffic_source_arbiter.sv
`timescale 1ns/1ps
// Scoreboard bench for traffic_source_arbiter with a source/age based model.
module tb_traffic_source_arbiter;

    localparam int MIN_DWELL    = 8;
    localparam int CLEAR_CYCLES = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] req = '0;
    logic [5:0] enb;
    logic       busy;
    logic       grant_chg;

    traffic_source_arbiter #(
        .MIN_DWELL   (MIN_DWELL),
        .CLEAR_CYCLES(CLEAR_CYCLES),
        .CW          (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .enb      (enb),
        .busy     (busy),
        .grant_chg(grant_chg)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0] enb;
        logic       busy;
        logic       chg;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Model: which source index is shown, how many edges it has been shown,
    // and whether a clearance is running toward a target source.
    int prio [6] = '{1, 0, 5, 4, 3, 2};
    int m_show;
    int m_tgt;
    int m_age;
    int m_clear_left;
    bit m_clearing;
    bit m_chg;

    function automatic int model_winner(input logic [5:0] r);
        for (int i = 0; i < 6; i++) begin
            if (r[prio[i]]) return prio[i];
        end
        return -1;
    endfunction

    function automatic void model_reset();
        m_show       = 1;
        m_tgt        = 1;
        m_age        = 0;
        m_clear_left = 0;
        m_clearing   = 1'b0;
        m_chg        = 1'b0;
    endfunction

    function automatic void model_step(input logic [5:0] r);
        int w;
        w     = model_winner(r);
        m_chg = 1'b0;
        if (r[1] && (m_show != 1 || m_clearing)) begin
            m_show     = 1;
            m_clearing = 1'b0;
            m_age      = 0;
            m_chg      = 1'b1;
        end else if (m_clearing) begin
            m_clear_left = m_clear_left - 1;
            if (m_clear_left == 0) begin
                m_clearing = 1'b0;
                m_show     = m_tgt;
                m_age      = 0;
                m_chg      = 1'b1;
            end
        end else if (m_age >= MIN_DWELL && w >= 0 && w != m_show) begin
            m_clearing   = 1'b1;
            m_clear_left = CLEAR_CYCLES;
            m_tgt        = w;
            m_show       = 1;
            m_chg        = 1'b1;
        end else begin
            m_age = m_age + 1;
        end
    endfunction

    // One clock: drive req at the falling edge, predict the post-edge outputs.
    task automatic cycle(input logic [5:0] r);
        exp_t       e;
        logic [5:0] one;
        @(negedge clk);
        req = r;
        model_step(r);
        one    = 6'b000001;
        e.enb  = one << m_show;
        e.busy = m_clearing;
        e.chg  = m_chg;
        exp_q.push_back(e);
        @(posedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        model_reset();
    endtask

    // Asserted between edges: outputs must return to reset values at once.
    task automatic async_reset_check();
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (enb !== 6'b000010 || busy !== 1'b0 || grant_chg !== 1'b0) begin
            errors++;
            $display("FAIL async_rst t=%0t got enb=%b busy=%b grant_chg=%b want enb=000010 busy=0 grant_chg=0",
                     $time, enb, busy, grant_chg);
        end
        req = '0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic bound_check(input bit ok, input string name);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s t=%0t condition not reached within cycle budget (got 0, want 1)", name, $time);
        end
    endtask

    // Monitor: every clock the DUT presents a new select; compare to the queue.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (enb !== e.enb || busy !== e.busy || grant_chg !== e.chg) begin
                    errors++;
                    $display("FAIL cycle_out t=%0t got enb=%b busy=%b grant_chg=%b want enb=%b busy=%b grant_chg=%b",
                             $time, enb, busy, grant_chg, e.enb, e.busy, e.chg);
                end
            end
        end
    end

    // Structural invariants sampled every falling edge across the whole run.
    always @(negedge clk) begin
        checks++;
        if (!$onehot(enb) || (busy === 1'b1 && enb !== 6'b000010)) begin
            errors++;
            $display("FAIL invariant t=%0t got enb=%b busy=%b want one-hot enb and busy->000010",
                     $time, enb, busy);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog t=%0t simulation did not complete (got timeout, want finish)", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [5:0] r;
        int hold;

        model_reset();
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;

        // 1: idle after reset.
        repeat (20) cycle(6'b000000);

        // 2: mode1 requested from the first cycle.
        do_reset();
        repeat (16) cycle(6'b100000);

        // 3: mode1 granted; mode4 joins during dwell, then mode1 drops.
        repeat (3) cycle(6'b100000);
        repeat (12) cycle(6'b100100);
        repeat (20) cycle(6'b000100);

        // 4: reset pattern aborts a clearance toward online.
        do_reset();
        n = 0;
        while (!m_clearing && n < 40) begin
            cycle(6'b000001);
            n++;
        end
        bound_check(m_clearing, "wait_clear_online");
        cycle(6'b000011);
        repeat (3) cycle(6'b000011);
        repeat (20) cycle(6'b000001);

        // 5: mode2 granted, online joins and wins.
        do_reset();
        n = 0;
        while (!(m_show == 4 && !m_clearing) && n < 40) begin
            cycle(6'b010000);
            n++;
        end
        bound_check(m_show == 4 && !m_clearing, "wait_mode2");
        repeat (20) cycle(6'b010001);

        // 6: asynchronous reset in the middle of a clearance.
        n = 0;
        while (!m_clearing && n < 40) begin
            cycle(6'b100000);
            n++;
        end
        bound_check(m_clearing, "wait_clear_mode1");
        async_reset_check();

        // Random request segments; the reset-pattern bit is kept rare.
        for (int seg = 0; seg < 150; seg++) begin
            r = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 7) != 0) r[1] = 1'b0;
            hold = $urandom_range(1, 20);
            for (int k = 0; k < hold; k++) cycle(r);
        end

        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain t=%0t got %0d pending want 0", $time, exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
